dense_argmax_engine: RTL and testbench



---
 rtl/nn_pkg.sv | 36 +++
 rtl/dense_argmax_engine_mac_lane.sv | 44 ++++
 rtl/dense_argmax_engine.sv | 147 ++++++++++++++
 tb/tb_dense_argmax_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the dense-layer / argmax engine.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ACCUM,
    S_FINAL,
    S_SCAN,
    S_DONE
  } state_t;

  localparam int DEF_N_IN   = 784;
  localparam int DEF_N_OUT  = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 48;

  // Helpers work on a fixed 64-bit signed carrier; callers sign-extend in and truncate out.
  localparam int MAX_W = 64;

  function automatic logic signed [MAX_W-1:0] relu(input logic signed [MAX_W-1:0] v);
    return v[MAX_W-1] ? '0 : v;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_to_data(input logic signed [MAX_W-1:0] v,
                                                          input int data_w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = 64'h7FFF_FFFF_FFFF_FFFF >> (MAX_W - data_w);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_argmax_engine_mac_lane.sv
// One neuron: bias-preloaded accumulator with a saturated (optionally ReLU'd) result register.
module mac_lane
  import nn_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAC_BITS = 0,
  parameter int RELU      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              acc_en,
  input  logic              fin,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    acc;
  logic signed [MAX_W-1:0]    acc_wide;
  logic        [DATA_W-1:0]   sat_val;

  assign prod     = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(w));
  assign addend   = ACC_W'(prod >>> FRAC_BITS);
  assign acc_wide = MAX_W'(acc);
  assign sat_val  = DATA_W'(sat_to_data((RELU != 0) ? relu(acc_wide) : acc_wide, DATA_W));

  // Accumulate stage: no reset on the accumulator, a frame always starts with a bias load.
  always_ff @(posedge clk) begin
    if (load)        acc <= ACC_W'($signed(bias));
    else if (acc_en) acc <= acc + addend;
  end

  // Result stage: captured once per frame, held until the next frame finishes.
  always_ff @(posedge clk) begin
    if (rst)      result <= '0;
    else if (fin) result <= sat_val;
  end

endmodule

// File: rtl/dense_argmax_engine.sv
// Time-multiplexed fully-connected layer: N_OUT parallel MAC lanes fed by a streamed
// input vector and a one-cycle-latency weight ROM, followed by a sequential argmax scan.
module dense_argmax_engine
  import nn_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int N_OUT     = DEF_N_OUT,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAC_BITS = 0,
  parameter int RELU      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_OUT*DATA_W-1:0]   bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic [$clog2(N_IN)-1:0]   w_addr,
  input  logic [N_OUT*DATA_W-1:0]   w_data,
  output logic                      busy,
  output logic                      out_valid,
  output logic [N_OUT*DATA_W-1:0]   out_data,
  output logic [$clog2(N_OUT)-1:0]  out_index,
  output logic [DATA_W-1:0]         out_max
);

  localparam int IW = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);

  state_t                   state_q;
  state_t                   state_d;
  logic [IW-1:0]            idx_q;
  logic [JW-1:0]            j_q;
  logic                     start_ok;
  logic                     accept;
  logic                     last_in;
  logic                     last_scan;
  logic                     fin;
  logic [DATA_W-1:0]        res [N_OUT];
  logic [JW-1:0]            cand_idx;
  logic signed [DATA_W-1:0] cand_max;
  logic [JW-1:0]            base_idx;
  logic signed [DATA_W-1:0] base_max;
  logic                     better;
  logic [JW-1:0]            sel_idx;
  logic signed [DATA_W-1:0] sel_max;

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = in_valid && (state_q == S_ACCUM);
  assign last_in   = accept && (idx_q == IW'(N_IN - 1));
  assign last_scan = (state_q == S_SCAN) && (j_q == JW'(N_OUT - 1));
  assign fin       = (state_q == S_FINAL);

  // Look one address ahead on accept so the next weight lands without a bubble.
  assign w_addr = idx_q + IW'(accept);

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    mac_lane #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .FRAC_BITS(FRAC_BITS),
      .RELU     (RELU)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (start_ok),
      .acc_en(accept),
      .fin   (fin),
      .bias  (bias[k*DATA_W +: DATA_W]),
      .x     (in_data),
      .w     (w_data[k*DATA_W +: DATA_W]),
      .result(res[k])
    );
    assign out_data[k*DATA_W +: DATA_W] = res[k];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRIME;
      S_PRIME: begin
        busy    = 1'b1;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (last_in) state_d = S_FINAL;
      end
      S_FINAL: begin
        busy    = 1'b1;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_scan) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_d   = start ? S_PRIME : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first scan step seeds the candidate with lane 0; later steps use the running best.
  assign base_idx = (j_q == JW'(1)) ? '0 : cand_idx;
  assign base_max = (j_q == JW'(1)) ? $signed(res[0]) : cand_max;
  assign better   = $signed(res[j_q]) > base_max;
  assign sel_idx  = better ? j_q : base_idx;
  assign sel_max  = better ? $signed(res[j_q]) : base_max;

  // Control stage: state, stream index, scan index and the published argmax.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      j_q       <= '0;
      out_index <= '0;
      out_max   <= '0;
    end else begin
      state_q <= state_d;
      if (last_in)     idx_q <= '0;
      else if (accept) idx_q <= idx_q + IW'(1);
      if (fin)                      j_q <= JW'(1);
      else if (state_q == S_SCAN)   j_q <= j_q + JW'(1);
      if (last_scan) begin
        out_index <= sel_idx;
        out_max   <= sel_max;
      end
    end
  end

  // Scan stage: running candidate, only meaningful while scanning.
  always_ff @(posedge clk) begin
    if (state_q == S_SCAN) begin
      cand_idx <= sel_idx;
      cand_max <= sel_max;
    end
  end

endmodule

// File: tb/tb_dense_argmax_engine.sv
// Directed bench: a linear and a ReLU instance share stimulus; a frame-level model plus
// a per-cycle comparator checks handshake timing, weight addressing and results.
module tb_dense_argmax_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, in_valid;
  logic [N_OUT*DW-1:0] bias;
  logic [DW-1:0]     in_data;
  logic [1:0]        wa_lin, wa_relu;
  logic [N_OUT*DW-1:0] wd_lin, wd_relu, od_lin, od_relu;
  logic              rdy_lin, rdy_relu, busy_lin, busy_relu, ov_lin, ov_relu;
  logic [1:0]        oi_lin, oi_relu;
  logic [DW-1:0]     om_lin, om_relu;

  int wt [N_IN][N_OUT];

  dense_argmax_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .ACC_W(48),
                        .FRAC_BITS(0), .RELU(0)) u_lin (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(rdy_lin), .in_data(in_data), .w_addr(wa_lin), .w_data(wd_lin),
    .busy(busy_lin), .out_valid(ov_lin), .out_data(od_lin), .out_index(oi_lin),
    .out_max(om_lin));

  dense_argmax_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .ACC_W(48),
                        .FRAC_BITS(0), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(rdy_relu), .in_data(in_data), .w_addr(wa_relu), .w_data(wd_relu),
    .busy(busy_relu), .out_valid(ov_relu), .out_data(od_relu), .out_index(oi_relu),
    .out_max(om_relu));

  always @(posedge clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      wd_lin[k*DW +: DW]  <= DW'(wt[wa_lin][k]);
      wd_relu[k*DW +: DW] <= DW'(wt[wa_relu][k]);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Expected timeline (cycle numbers) and results, index 0 = linear, 1 = ReLU.
  int busy_lo = -10, busy_hi = -20, rdy_lo = -10, rdy_hi = -20, ov_at = -1, win_lo = -10;
  longint fin_v [N_IN];
  longint fb [N_OUT];
  longint pend_d [2][N_OUT];
  longint cur_d  [2][N_OUT];
  int     pend_i [2];
  int     cur_i  [2];
  longint pend_m [2];
  longint cur_m  [2];
  int     acc_cnt = 0;
  bit     rst_seen = 1'b0;

  task automatic run_model();
    longint a;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N_OUT; k++) begin
        a = fb[k];
        for (int i = 0; i < N_IN; i++) a += fin_v[i] * wt[i][k];
        if (d == 1 && a < 0) a = 0;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        pend_d[d][k] = a;
      end
      pend_i[d] = 0;
      pend_m[d] = pend_d[d][0];
      for (int k = 1; k < N_OUT; k++)
        if (pend_d[d][k] > pend_m[d]) begin
          pend_i[d] = k;
          pend_m[d] = pend_d[d][k];
        end
    end
  endtask

  always @(negedge clk) begin : cmp
    bit eb, er, eo, an;
    logic [N_OUT*DW-1:0] od;
    logic [DW-1:0] om;
    logic [1:0] oi, wa;
    logic ob, ordy, oov;
    if (rst) rst_seen = 1'b1;
    else begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        busy_lo = -10; busy_hi = -20; rdy_lo = -10; rdy_hi = -20; ov_at = -1; win_lo = -10;
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < N_OUT; k++) cur_d[d][k] = 0;
          cur_i[d] = 0;
          cur_m[d] = 0;
        end
      end
      if (cyc == ov_at) begin
        cur_d = pend_d;
        cur_i = pend_i;
        cur_m = pend_m;
      end
      if (cyc == win_lo) acc_cnt = 0;
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      er = (cyc >= rdy_lo) && (cyc <= rdy_hi);
      eo = (cyc == ov_at);
      an = er && in_valid;
      for (int d = 0; d < 2; d++) begin
        od = d ? od_relu : od_lin;   om = d ? om_relu : om_lin;
        oi = d ? oi_relu : oi_lin;   wa = d ? wa_relu : wa_lin;
        ob = d ? busy_relu : busy_lin;
        ordy = d ? rdy_relu : rdy_lin;
        oov = d ? ov_relu : ov_lin;
        chk($sformatf("busy[%0d]", d), longint'(ob), longint'(eb));
        chk($sformatf("in_ready[%0d]", d), longint'(ordy), longint'(er));
        chk($sformatf("out_valid[%0d]", d), longint'(oov), longint'(eo));
        if (!eb) begin
          for (int k = 0; k < N_OUT; k++)
            chk($sformatf("out_data[%0d][%0d]", d, k), longint'($signed(od[k*DW +: DW])),
                cur_d[d][k]);
          chk($sformatf("out_index[%0d]", d), longint'(oi), longint'(cur_i[d]));
          chk($sformatf("out_max[%0d]", d), longint'($signed(om)), cur_m[d]);
        end
        if (cyc >= win_lo && cyc <= rdy_hi)
          chk($sformatf("w_addr[%0d]", d), longint'(wa), longint'((acc_cnt + an) % 4));
      end
      acc_cnt += an;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input longint i0, input longint i1, input longint i2, input longint i3,
                         input longint b0, input longint b1, input longint b2);
    fin_v[0] = i0; fin_v[1] = i1; fin_v[2] = i2; fin_v[3] = i3;
    fb[0] = b0; fb[1] = b1; fb[2] = b2;
  endtask

  // gap: idle cycles between elements; mid_start/abort_at: element index or -1.
  task automatic frame(input int gap, input int mid_start, input int abort_at, input int lat);
    int s, t, n;
    run_model();
    s = cyc;
    t = s + 2 + (N_IN - 1) * (gap + 1);
    bias = {DW'(fb[2]), DW'(fb[1]), DW'(fb[0])};
    busy_lo = s + 1; busy_hi = t + N_OUT;
    rdy_lo = s + 2;  rdy_hi = t;
    ov_at = t + N_OUT + 1;
    win_lo = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'd555;
    tick();
    for (int i = 0; i < N_IN; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        return;
      end
      in_valid = 1'b1;
      in_data = DW'(fin_v[i]);
      start = (i == mid_start);
      tick();
      start = 1'b0;
      if (i < N_IN - 1)
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data = 16'h7fff;
          tick();
        end
    end
    in_valid = 1'b0;
    n = 0;
    while (!ov_lin && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("out_valid_timeout", 0, 1);
    chk("latency", cyc - s, lat);
  endtask

  task automatic pin_basic();
    chk("pin_basic_n0", $signed(od_lin[0 +: DW]), 10);
    chk("pin_basic_n1", $signed(od_lin[DW +: DW]), 7);
    chk("pin_basic_n2", $signed(od_lin[2*DW +: DW]), 11);
    chk("pin_basic_idx", oi_lin, 2);
    chk("pin_basic_max", $signed(om_lin), 11);
  endtask

  initial begin
    wt = '{'{1, 2, 0}, '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 3}};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    set_vec(1, 2, 3, 4, 0, 5, -1);
    frame(0, -1, -1, 9);
    pin_basic();
    repeat (2) tick();

    set_vec(1, 2, 3, 4, -20, 4, 4);
    frame(0, -1, -1, 9);
    chk("pin_relu_n0", $signed(od_relu[0 +: DW]), 0);
    chk("pin_relu_n1", $signed(od_relu[DW +: DW]), 6);
    chk("pin_relu_n2", $signed(od_relu[2*DW +: DW]), 16);
    chk("pin_lin_neg_n0", $signed(od_lin[0 +: DW]), -10);
    repeat (2) tick();

    set_vec(1, 2, 3, 4, -4, 4, -9);
    frame(0, -1, -1, 9);
    chk("pin_tie_idx", oi_lin, 0);
    chk("pin_tie_max", $signed(om_lin), 6);
    repeat (2) tick();

    set_vec(1, 2, 3, 4, -20, -18, -26);
    frame(0, -1, -1, 9);
    chk("pin_negtie_idx", oi_lin, 0);
    chk("pin_negtie_max", $signed(om_lin), -10);
    chk("pin_negtie_relu_max", $signed(om_relu), 0);
    repeat (2) tick();

    set_vec(30000, 30000, 30000, 30000, 0, 0, 0);
    frame(0, -1, -1, 9);
    chk("pin_sat_hi", $signed(od_lin[0 +: DW]), 32767);
    chk("pin_sat_hi_idx", oi_lin, 0);
    repeat (2) tick();

    set_vec(-30000, -30000, -30000, -30000, 0, 0, 0);
    frame(0, -1, -1, 9);
    chk("pin_sat_lo", $signed(od_lin[0 +: DW]), -32768);
    chk("pin_sat_lo_relu", $signed(od_relu[0 +: DW]), 0);
    repeat (2) tick();

    set_vec(1, 2, 3, 4, 0, 5, -1);
    frame(2, -1, -1, 15);
    pin_basic();
    repeat (2) tick();

    frame(0, 1, -1, 9);
    pin_basic();
    repeat (2) tick();

    set_vec(-7, 9, 100, 3, 11, 12, 13);
    frame(0, -1, 2, 0);
    chk("pin_abort_data", od_lin, 0);
    chk("pin_abort_busy", busy_lin, 0);

    set_vec(1, 2, 3, 4, 0, 5, -1);
    frame(0, -1, -1, 9);
    pin_basic();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
